// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   // DMType codes as driven by the core; fetches always go out as a full word.
   typedef enum logic [2:0] {
      DMT_WORD   = 3'd0,
      DMT_HALF   = 3'd1,
      DMT_HALF_U = 3'd2,
      DMT_BYTE   = 3'd3,
      DMT_BYTE_U = 3'd4
   } dm_type_e;

   localparam int STREAK_W = 4;
   localparam logic [STREAK_W-1:0] STREAK_SAT = 4'd15;

   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
      return (s == STREAK_SAT) ? s : s + 1'b1;
   endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// rtl/mem_bus_watchdog.sv - cycle counter that flags a bus access running too long
module mem_bus_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   // Counter reads k-1 during the k-th enabled cycle, so expiry lands on cycle TIMEOUT_CYC.
   localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          at_limit;

   assign at_limit = (cnt_q == LIMIT);
   assign expired  = (TIMEOUT_CYC > 0) && enable && at_limit;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !at_limit) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between instruction fetch and data ports
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC   = 64,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [2:0]  dm_type,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [2:0]  bus_type,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        stall,
   output logic        err,
   output logic [31:0] err_addr
);
   localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DM_STREAK);

   arb_state_e          state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                bus_req_q, bus_req_d;
   logic                bus_we_q, bus_we_d;
   logic [31:0]         bus_addr_q, bus_addr_d;
   logic [31:0]         bus_wdata_q, bus_wdata_d;
   logic [2:0]          bus_type_q, bus_type_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         dm_rdata_q, dm_rdata_d;
   logic                err_q, err_d;
   logic [31:0]         err_addr_q, err_addr_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                wd_expired;
   logic                grant_dm;

   mem_bus_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q != BUSY),
      .enable  (state_q == BUSY),
      .expired (wd_expired)
   );

   // Data wins contention until it has taken STREAK_LIMIT grants in a row over a waiting fetch.
   assign grant_dm = dm_req && (!if_req || (streak_q < STREAK_LIMIT));

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_type_d  = bus_type_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      err_d       = 1'b0;
      err_addr_d  = err_addr_q;
      streak_d    = streak_q;
      case (state_q)
         IDLE: begin
            if (grant_dm) begin
               owner_d     = OWN_DM;
               bus_we_d    = dm_we;
               bus_addr_d  = dm_addr;
               bus_wdata_d = dm_wdata;
               bus_type_d  = dm_type;
               bus_req_d   = 1'b1;
               streak_d    = if_req ? streak_inc(streak_q) : '0;
               state_d     = BUSY;
            end else if (if_req) begin
               owner_d     = OWN_IF;
               bus_we_d    = 1'b0;
               bus_addr_d  = if_addr;
               bus_wdata_d = '0;
               bus_type_d  = DMT_WORD;
               bus_req_d   = 1'b1;
               streak_d    = '0;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (bus_ack) begin
               if (owner_q == OWN_IF) if_rdata_d = bus_rdata;
               else                   dm_rdata_d = bus_rdata;
               bus_req_d = 1'b0;
               state_d   = RESP;
            end else if (wd_expired) begin
               if (owner_q == OWN_IF) if_rdata_d = '0;
               else                   dm_rdata_d = '0;
               err_d      = 1'b1;
               err_addr_d = bus_addr_q;
               bus_req_d  = 1'b0;
               state_d    = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_type_q  <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         err_q       <= 1'b0;
         err_addr_q  <= '0;
         streak_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_type_q  <= bus_type_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         err_q       <= err_d;
         err_addr_q  <= err_addr_d;
         streak_q    <= streak_d;
      end
   end

   assign if_ready  = (state_q == RESP) && (owner_q == OWN_IF);
   assign dm_ready  = (state_q == RESP) && (owner_q == OWN_DM);
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_type  = bus_type_q;
   assign err       = err_q;
   assign err_addr  = err_addr_q;
   // Reset must silence the hazard unit at once, even while requests are still asserted.
   assign stall     = ~rst & ((if_req & ~if_ready) | (dm_req & ~dm_ready));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [2:0]  dm_type = '0;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata, err_addr;
   logic        if_ready, dm_ready, bus_req, bus_we, stall, err;
   logic [2:0]  bus_type;

   logic [31:0] if_rdata3, dm_rdata3, bus_addr3, bus_wdata3, err_addr3;
   logic        if_ready3, dm_ready3, bus_req3, bus_we3, stall3, err3;
   logic [2:0]  bus_type3;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT_CYC(8), .MAX_DM_STREAK(4)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_type(dm_type),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_type(bus_type),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall(stall), .err(err), .err_addr(err_addr)
   );

   mem_port_arbiter #(.TIMEOUT_CYC(3), .MAX_DM_STREAK(4)) u_dut3 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata3), .if_ready(if_ready3),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_type(dm_type),
      .dm_rdata(dm_rdata3), .dm_ready(dm_ready3),
      .bus_req(bus_req3), .bus_we(bus_we3), .bus_addr(bus_addr3), .bus_wdata(bus_wdata3), .bus_type(bus_type3),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall(stall3), .err(err3), .err_addr(err_addr3)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [2:0]  dm_type;
      logic        ack;
      logic [31:0] rdata;
      logic        e_bus_req;
      logic        e_bus_we;
      logic [31:0] e_bus_addr;
      logic [31:0] e_bus_wdata;
      logic [2:0]  e_bus_type;
      logic        e_if_ready;
      logic        e_dm_ready;
      logic        e_stall;
      logic        e_err;
      int          chk_rd;
      logic [31:0] e_rdata;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [9:0]  order;
      int          n_grants;
      int          busy_cycles;
      logic        got;

      // single fetch, then simultaneous store + fetch
      vecs[0]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[1]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[2]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[3]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b1, 32'h00500093, 1'b1, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[4]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,  32'h0,        3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h00500093};
      vecs[5]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,    32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h00500093};
      vecs[6]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100,  32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[7]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b1, 32'hAAAA5555, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[8]  = '{1'b1, 32'h104, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 2, 32'hAAAA5555};
      vecs[9]  = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[10] = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b1, 32'h11111111, 1'b1, 1'b0, 32'h104,  32'h0,        3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0};
      vecs[11] = '{1'b1, 32'h104, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0, 1'b0, 32'h104,  32'h0,        3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h11111111};
      vecs[12] = '{1'b0, 32'h104, 1'b0, 1'b1, 32'h2000, 32'hDEADBEEF, 3'd2, 1'b0, 32'h0,        1'b0, 1'b0, 32'h104,  32'h0,        3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 32'hAAAA5555};

      // reset state
      #3;
      check("rst bus_req", {31'b0, bus_req}, 32'h0);
      check("rst bus_addr", bus_addr, 32'h0);
      check("rst err_addr", err_addr, 32'h0);
      check("rst dut8 any output", {31'b0, |{if_rdata, if_ready, dm_rdata, dm_ready, bus_req, bus_we,
            bus_addr, bus_wdata, bus_type, stall, err, err_addr}}, 32'h0);
      check("rst dut3 any output", {31'b0, |{if_rdata3, if_ready3, dm_rdata3, dm_ready3, bus_req3, bus_we3,
            bus_addr3, bus_wdata3, bus_type3, stall3, err3, err_addr3}}, 32'h0);
      step();
      step();
      rst = 1'b0;

      foreach (vecs[i]) begin
         if_req    = vecs[i].if_req;
         if_addr   = vecs[i].if_addr;
         dm_req    = vecs[i].dm_req;
         dm_we     = vecs[i].dm_we;
         dm_addr   = vecs[i].dm_addr;
         dm_wdata  = vecs[i].dm_wdata;
         dm_type   = vecs[i].dm_type;
         bus_ack   = vecs[i].ack;
         bus_rdata = vecs[i].rdata;
         #1;
         check($sformatf("vec%0d bus_req", i), {31'b0, bus_req}, {31'b0, vecs[i].e_bus_req});
         check($sformatf("vec%0d bus_we", i), {31'b0, bus_we}, {31'b0, vecs[i].e_bus_we});
         check($sformatf("vec%0d bus_addr", i), bus_addr, vecs[i].e_bus_addr);
         check($sformatf("vec%0d bus_wdata", i), bus_wdata, vecs[i].e_bus_wdata);
         check($sformatf("vec%0d bus_type", i), {29'b0, bus_type}, {29'b0, vecs[i].e_bus_type});
         check($sformatf("vec%0d if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].e_if_ready});
         check($sformatf("vec%0d dm_ready", i), {31'b0, dm_ready}, {31'b0, vecs[i].e_dm_ready});
         check($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
         check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
         if (vecs[i].chk_rd == 1) check($sformatf("vec%0d if_rdata", i), if_rdata, vecs[i].e_rdata);
         if (vecs[i].chk_rd == 2) check($sformatf("vec%0d dm_rdata", i), dm_rdata, vecs[i].e_rdata);
         step();
      end

      // starvation guard: both ports hammering, memory acks immediately
      if_req = 1'b1; if_addr = 32'h400;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500; dm_type = 3'd4;
      bus_rdata = 32'h5A5A0000;
      order = '0;
      n_grants = 0;
      for (int c = 0; c < 60 && n_grants < 10; c++) begin
         bus_ack = bus_req;
         if (bus_req) begin
            order = {order[8:0], (bus_addr == 32'h500)};
            n_grants++;
         end
         step();
      end
      if_req = 1'b0; dm_req = 1'b0; bus_ack = 1'b0;
      check("starve grant count", n_grants, 10);
      check("starve grant order", {22'b0, order}, {22'b0, 10'b1111011110});
      step();
      step();

      // watchdog abort of a load that is never acknowledged
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000; dm_type = 3'd0;
      step();
      busy_cycles = 0;
      for (int c = 0; c < 20 && !dm_ready; c++) begin
         if (bus_req) busy_cycles++;
         check($sformatf("timeout no early err c%0d", c), {31'b0, err}, 32'h0);
         step();
      end
      check("timeout busy cycles", busy_cycles, 8);
      check("timeout dm_ready", {31'b0, dm_ready}, 32'h1);
      check("timeout err", {31'b0, err}, 32'h1);
      check("timeout err_addr", err_addr, 32'h3000);
      check("timeout dm_rdata", dm_rdata, 32'h0);
      check("timeout bus_req", {31'b0, bus_req}, 32'h0);
      dm_req = 1'b0;
      step();
      check("timeout err pulse", {31'b0, err}, 32'h0);
      check("timeout ready pulse", {31'b0, dm_ready}, 32'h0);
      repeat (4) step();
      bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
      step();
      bus_ack = 1'b0;
      #1;
      check("late ack dm_ready", {31'b0, dm_ready}, 32'h0);
      check("late ack bus_req", {31'b0, bus_req}, 32'h0);
      check("late ack dm_rdata", dm_rdata, 32'h0);
      check("late ack err_addr", err_addr, 32'h3000);
      step();

      // asynchronous reset in the middle of a fetch
      if_req = 1'b1; if_addr = 32'h80;
      step();
      check("rst mid busy", {31'b0, bus_req}, 32'h1);
      rst = 1'b1;
      #1;
      check("rst mid bus_req", {31'b0, bus_req}, 32'h0);
      check("rst mid if_ready", {31'b0, if_ready}, 32'h0);
      check("rst mid dm_ready", {31'b0, dm_ready}, 32'h0);
      check("rst mid stall", {31'b0, stall}, 32'h0);
      step();
      if_req = 1'b0;
      rst = 1'b0;
      bus_ack = 1'b1; bus_rdata = 32'h77;
      step();
      bus_ack = 1'b0;
      #1;
      check("rst late ack if_ready", {31'b0, if_ready}, 32'h0);
      check("rst late ack if_rdata", if_rdata, 32'h0);
      if_req = 1'b1; if_addr = 32'h0; bus_rdata = 32'h00000013;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         if (if_ready) begin
            got = 1'b1;
            check("rst fresh if_rdata", if_rdata, 32'h00000013);
         end else begin
            bus_ack = bus_req;
            if (bus_req) check("rst fresh bus_addr", bus_addr, 32'h0);
            step();
         end
      end
      check("rst fresh completed", {31'b0, got}, 32'h1);
      if_req = 1'b0; bus_ack = 1'b0;
      step();

      // ack arrives on the same cycle the 3-cycle watchdog expires
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h600;
      step();
      check("coincide busy", {31'b0, bus_req3}, 32'h1);
      step();
      step();
      bus_ack = 1'b1; bus_rdata = 32'h1234;
      step();
      bus_ack = 1'b0;
      check("coincide dm_ready", {31'b0, dm_ready3}, 32'h1);
      check("coincide no err", {31'b0, err3}, 32'h0);
      check("coincide dm_rdata", dm_rdata3, 32'h1234);
      check("coincide err_addr", err_addr3, 32'h0);
      dm_req = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
